// File: rtl/ir_move_transmitter_pkg.sv
// Shared SIRC framing constants and state encoding for the IR move link.
// The rover-side receiver imports the same numbers so both ends agree on timing.
package ir_move_transmitter_pkg;

  localparam int IR_UNIT_CYCLES  = 16200;
  localparam int IR_CARRIER_HALF = 337;
  localparam int IR_FRAME_UNITS  = 75;
  localparam int IR_REPEATS      = 3;

  localparam int IR_HEADER_UNITS = 4;
  localparam int IR_GAP_UNITS    = 1;
  localparam int IR_ONE_UNITS    = 2;
  localparam int IR_ZERO_UNITS   = 1;
  localparam int IR_NUM_BITS     = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_GAP    = 3'd2,
    ST_BIT    = 3'd3,
    ST_PAD    = 3'd4,
    ST_DONE   = 3'd5
  } ir_state_t;

  // Unit down-counter load value for a data mark (terminal count is zero).
  function automatic logic [1:0] mark_units_last(input logic b);
    return b ? 2'(IR_ONE_UNITS - 1) : 2'(IR_ZERO_UNITS - 1);
  endfunction

endpackage

// File: rtl/ir_move_transmitter_carrier_gen.sv
// ~40 kHz carrier: half-period down-counter that toggles on terminal count.
// A restart forces the phase high so every mark begins with a full high half.
module ir_carrier_gen #(
  parameter int HALF = 337
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic carrier
);

  localparam int CW = $clog2(HALF + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  logic [CW-1:0] half_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      half_cnt <= '0;
      carrier  <= 1'b0;
    end else if (restart) begin
      half_cnt <= HALF_LAST;
      carrier  <= 1'b1;
    end else if (half_cnt == '0) begin
      half_cnt <= HALF_LAST;
      carrier  <= ~carrier;
    end else begin
      half_cnt <= half_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ir_move_transmitter.sv
// Serialises a 12-bit move command into repeated SIRC-style IR frames.
//
//   state  | meaning
//   IDLE   | waiting for transmit, busy low
//   HEADER | 4-unit mark opening each frame
//   GAP    | 1-unit space before each data bit
//   BIT    | data mark, 1 unit for 0 / 2 units for 1, LSB first
//   PAD    | space until the frame reaches FRAME_UNITS
//   DONE   | one-cycle done pulse, then IDLE
module ir_move_transmitter
  import ir_move_transmitter_pkg::*;
#(
  parameter int UNIT_CYCLES  = IR_UNIT_CYCLES,
  parameter int CARRIER_HALF = IR_CARRIER_HALF,
  parameter int FRAME_UNITS  = IR_FRAME_UNITS,
  parameter int REPEATS      = IR_REPEATS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        transmit,
  input  logic [11:0] command,
  output logic        ir_out,
  output logic        ir_envelope,
  output logic        busy,
  output logic        done
);

  localparam logic [14:0] UNIT_LAST   = 15'(UNIT_CYCLES - 1);
  localparam logic [6:0]  FRAME_LAST  = 7'(FRAME_UNITS - 1);
  localparam logic [2:0]  REP_LAST    = 3'(REPEATS - 1);
  localparam logic [3:0]  BIT_LAST    = 4'(IR_NUM_BITS - 1);
  localparam logic [1:0]  HEADER_LAST = 2'(IR_HEADER_UNITS - 1);
  localparam logic [1:0]  GAP_LAST    = 2'(IR_GAP_UNITS - 1);

  ir_state_t   state;
  logic [14:0] cycle_cnt;
  logic [6:0]  frame_units;
  logic [3:0]  bit_idx;
  logic [2:0]  repeat_cnt;
  logic [1:0]  unit_cnt;
  logic [11:0] shreg;
  logic        carrier;

  logic start;
  logic unit_tick;
  logic unit_end;
  logic pad_end;
  logic more_frames;
  logic restart;

  always_comb begin
    start       = (state == ST_IDLE) && transmit;
    unit_tick   = (state inside {ST_HEADER, ST_GAP, ST_BIT, ST_PAD}) && (cycle_cnt == '0);
    unit_end    = unit_tick && (unit_cnt == '0);
    pad_end     = unit_tick && (state == ST_PAD) && (frame_units == FRAME_LAST);
    more_frames = (repeat_cnt != REP_LAST);
    // Carrier phase restarts on the edge that begins each mark.
    restart     = start || (unit_end && (state == ST_GAP)) || (pad_end && more_frames);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else if (start) begin
      cycle_cnt <= UNIT_LAST;
    end else if (state inside {ST_HEADER, ST_GAP, ST_BIT, ST_PAD}) begin
      cycle_cnt <= (cycle_cnt == '0) ? UNIT_LAST : cycle_cnt - 1'b1;
    end else begin
      cycle_cnt <= '0;
    end
  end

  // Units elapsed since the current frame's header began.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_units <= '0;
    end else if (start || pad_end) begin
      frame_units <= '0;
    end else if (unit_tick) begin
      frame_units <= frame_units + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      unit_cnt    <= '0;
      bit_idx     <= '0;
      repeat_cnt  <= '0;
      shreg       <= '0;
      ir_envelope <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (transmit) begin
            shreg       <= command;
            repeat_cnt  <= '0;
            bit_idx     <= '0;
            unit_cnt    <= HEADER_LAST;
            state       <= ST_HEADER;
            busy        <= 1'b1;
            ir_envelope <= 1'b1;
          end
        end
        ST_HEADER: begin
          if (unit_end) begin
            state       <= ST_GAP;
            unit_cnt    <= GAP_LAST;
            ir_envelope <= 1'b0;
          end else if (unit_tick) begin
            unit_cnt <= unit_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (unit_end) begin
            state       <= ST_BIT;
            unit_cnt    <= mark_units_last(shreg[0]);
            ir_envelope <= 1'b1;
          end else if (unit_tick) begin
            unit_cnt <= unit_cnt - 1'b1;
          end
        end
        ST_BIT: begin
          if (unit_end) begin
            // Rotating rather than shifting leaves the command intact after 12 bits.
            shreg       <= {shreg[0], shreg[11:1]};
            ir_envelope <= 1'b0;
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              state   <= ST_PAD;
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              unit_cnt <= GAP_LAST;
              state    <= ST_GAP;
            end
          end else if (unit_tick) begin
            unit_cnt <= unit_cnt - 1'b1;
          end
        end
        ST_PAD: begin
          if (pad_end) begin
            if (more_frames) begin
              repeat_cnt  <= repeat_cnt + 1'b1;
              unit_cnt    <= HEADER_LAST;
              state       <= ST_HEADER;
              ir_envelope <= 1'b1;
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  ir_carrier_gen #(
    .HALF(CARRIER_HALF)
  ) u_carrier (
    .clock  (clock),
    .reset  (reset),
    .restart(restart),
    .carrier(carrier)
  );

  assign ir_out = ir_envelope & carrier;

endmodule
